period_meter: RTL and testbench
===============================

# period_meter

Measures the period of a slow, asynchronous square wave in system-clock cycles; the inverse of the clock divider. A divided clock (or any external slow signal) enters on `sig_in`. The block reports the number of `clk` cycles between consecutive rising edges. It sits beside the divider in the clock/timing group and serves as a self-check of divider output and as a generic frequency meter.

## Interface
Parameters:
- `CNT_W`, 32: width of the period counter and of `period`.
- `TIMEOUT`, 200_000_000: cycle count without a rising edge that declares loss of signal. Must be less than 2^CNT_W.

Ports (clock and reset first):
- `clk`  in  1  system clock. The block uses this single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sig_in`  in  1  measured signal. Asynchronous to `clk`.
- `clr`  in  1  synchronous clear of measurement state. Active-high.
- `period`  out  CNT_W  last measured period, in `clk` cycles.
- `valid`  out  1  one-cycle pulse. Asserted in the cycle `period` updates.
- `locked`  out  1  high while consecutive edges arrive within `TIMEOUT`.
- `timeout`  out  1  sticky loss-of-signal flag.
- `high_time`  out  CNT_W  cycles `sig_in` was high in the last period. See Configuration.

## Operation
Input conditioning:
- `sig_in` passes through a 2-flop synchronizer, giving `s_sync`.
- A registered copy of `s_sync` provides `s_d`.
- `rise` = `s_sync & ~s_d`; `fall` = `~s_sync & s_d`.

State machine (IDLE, MEASURE, STALL):
- IDLE (entered at reset or `clr`):
  - `cnt` = 0; no reporting.
  - On `rise`: go to MEASURE, set `cnt` = 1.
- MEASURE:
  - Each cycle, `cnt` increments by 1.
  - On `rise`: `period` <= `cnt`, `valid` = 1 for one cycle, `cnt` <= 1.
  - The first `rise` after entering MEASURE from IDLE or STALL only arms the counter; it never produces `valid`.
  - If `cnt` reaches `TIMEOUT` with no `rise`: go to STALL, set `timeout` = 1. `period` holds.
- STALL:
  - `cnt` saturates at `TIMEOUT`.
  - On `rise`: go to MEASURE, set `cnt` = 1, no `valid`.
  - `timeout` stays set until `clr` or reset.

Outputs and arithmetic:
- `locked` = 1 only after at least one `valid` since the last entry into MEASURE, and while in MEASURE.
- `cnt` never wraps. It saturates at `TIMEOUT`.
- Priority: `rst_n` > `clr` > `rise`. If `clr` and `rise` occur in the same cycle, the result is IDLE with `cnt` = 0 and no `valid`.

## Timing
Reset values (all outputs): `period` = 0, `valid` = 0, `locked` = 0, `timeout` = 0, `high_time` = 0. Internally, state = IDLE and `cnt` = 0.

Latency and alignment:
- Latency from a `sig_in` rising edge to `valid` is 3 `clk` cycles: 2 synchronizer cycles plus 1 register cycle.
- `period` and `valid` change on the same clock edge.
- `period` is stable until the next `valid`.

Measurement behaviour:
- A divider that toggles every H cycles yields `period` = 2H exactly, with no ±1 jitter. This holds because the input is synchronous.
- Asynchronous inputs give ±1 jitter.
- Pulses shorter than 2 `clk` cycles may be missed. Such inputs are out of spec.

`clr` and reset:
- `clr` takes effect at the next edge: `period`, `high_time`, `timeout`, `locked` and `cnt` clear, and the state becomes IDLE.
- Reset asserted mid-measurement clears everything immediately (asynchronous). The measurement restarts from IDLE after release.

## Configuration
- `PERIOD_METER_HIGH_EN` defined:
  - A second counter `hcnt` is cleared to 1 on `rise` and increments while `s_sync` is high.
  - `hcnt` is captured to a holding register on `fall`.
  - `high_time` updates with `period` on `valid`, from that holding register.
- `PERIOD_METER_HIGH_EN` undefined: `high_time` is tied to 0. No `hcnt` logic is present.

## Structure
- Shared package/header `period_meter_pkg` holds:
  - the state encoding constants (IDLE = 2'd0, MEASURE = 2'd1, STALL = 2'd2);
  - the default `CNT_W` and `TIMEOUT`.
- One sub-module, `sync_2ff`: a 2-flop synchronizer with async active-low reset to 0. It is reused by other async-input blocks.
- Edge detect, FSM, counters and output registers live in `period_meter` itself.

## Test plan
- Reset: hold `rst_n` = 0 with `sig_in` toggling -> all outputs 0. After release, the first `rise` gives no `valid`.
- Steady toggle: `sig_in` toggles every 5 `clk` cycles -> the second and later `rise` give `valid` with `period` = 10 and `locked` = 1. Check that `valid` is a single-cycle pulse.
- Loss of signal with `TIMEOUT` = 50: stop toggling -> exactly 50 cycles after the last `cnt` reset, `timeout` = 1, `locked` = 0, `period` holds 10. On restart, the first `rise` gives no `valid`; the next gives `valid` with `timeout` still 1.
- Clear collision: assert `clr` in the same cycle as `rise` -> IDLE, no `valid`, `period` = 0, `timeout` = 0.
- Duty cycle (`PERIOD_METER_HIGH_EN`): high 3, low 7 -> `period` = 10 and `high_time` = 3. Without the macro, `high_time` = 0.
- Period change: half-period switches from 5 to 8 -> one transitional report, then `period` = 16 steady.

Source files
------------

// File: rtl/period_meter_pkg.sv
// -----------------------------------------------------------------------------
// period_meter_pkg
//
// Definitions shared by the period meter and its helpers:
//   - state_e     : measurement FSM encoding (IDLE / MEASURE / STALL)
//   - CNT_W_DEF   : default width of the period counter and outputs
//   - TIMEOUT_DEF : default loss-of-signal limit, in clk cycles
// -----------------------------------------------------------------------------
package period_meter_pkg;

    localparam int CNT_W_DEF   = 32;
    localparam int TIMEOUT_DEF = 200_000_000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALL   = 2'd2
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//
// Two-flop synchronizer for a single asynchronous level signal. Both flops
// reset asynchronously to 0. Shared by the async-input blocks of the
// clock/timing group.
//
// Ports:
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset
//   d_i   in  asynchronous input level
//   q_o   out input level synchronized to clk (2-cycle latency)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
//
// Measures the period of a slow square wave on sig_in, in clk cycles, between
// consecutive rising edges. The input is synchronized, edge-detected and fed
// to a small FSM (IDLE -> MEASURE <-> STALL) that counts cycles, reports each
// completed period with a one-cycle valid pulse and flags loss of signal when
// no rising edge arrives within TIMEOUT cycles.
//
// Optional feature, enabled by defining PERIOD_METER_HIGH_EN:
//   high_time reports how many cycles the signal was high within the period
//   reported by the same valid pulse. Without the macro high_time is tied 0.
//
// Parameters:
//   CNT_W    width of the period counter, period and high_time
//   TIMEOUT  cycles without a rising edge that declare loss of signal
//            (must be below 2**CNT_W)
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   sig_in     in   measured signal, asynchronous to clk
//   clr        in   synchronous clear of all measurement state
//   period     out  last measured period in clk cycles
//   valid      out  one-cycle pulse in the cycle period updates
//   locked     out  high while periods are being reported in MEASURE
//   timeout    out  sticky loss-of-signal flag
//   high_time  out  high cycles of the last reported period (optional)
// -----------------------------------------------------------------------------
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             locked,
    output logic             timeout,
    output logic [CNT_W-1:0] high_time
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    // Counters never wrap: they stop at TIMEOUT.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= TIMEOUT_C) ? TIMEOUT_C : v + ONE_C;
    endfunction

    // -------------------------------------------------------------------------
    // Input conditioning
    // -------------------------------------------------------------------------
    logic s_sync;
    logic s_d_q;
    logic rise;
    logic report;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (sig_in),
        .q_o   (s_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_d_q <= 1'b0;
        end else begin
            s_d_q <= s_sync;
        end
    end

    assign rise = s_sync & ~s_d_q;

    // -------------------------------------------------------------------------
    // Measurement FSM, period counter and output registers
    // -------------------------------------------------------------------------
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] period_q;
    logic             valid_q;
    logic             locked_q;
    logic             timeout_q;

    // A rise while already in MEASURE closes a period. The rise that moves
    // IDLE/STALL into MEASURE only arms the counter, so it never reports.
    assign report = (state_q == MEASURE) && rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else if (clr) begin
            // clr outranks a simultaneous rise: nothing is reported
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q    <= '0;
                    locked_q <= 1'b0;
                    if (rise) begin
                        state_q <= MEASURE;
                        cnt_q   <= ONE_C;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_q <= cnt_q;
                        valid_q  <= 1'b1;
                        locked_q <= 1'b1;
                        cnt_q    <= ONE_C;
                    end else if (cnt_q >= TIMEOUT_C) begin
                        // period_q is deliberately left holding the last value
                        state_q   <= STALL;
                        timeout_q <= 1'b1;
                        locked_q  <= 1'b0;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
                STALL: begin
                    cnt_q    <= sat_inc(cnt_q);
                    locked_q <= 1'b0;
                    if (rise) begin
                        state_q <= MEASURE;
                        cnt_q   <= ONE_C;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    cnt_q    <= '0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign period  = period_q;
    assign valid   = valid_q;
    assign locked  = locked_q;
    assign timeout = timeout_q;

    // -------------------------------------------------------------------------
    // Optional high-time measurement
    // -------------------------------------------------------------------------
`ifdef PERIOD_METER_HIGH_EN
    logic             fall;
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] hhold_q;
    logic [CNT_W-1:0] high_time_q;

    assign fall = ~s_sync & s_d_q;

    // hcnt starts at 1 on the rise cycle and counts every further high cycle;
    // the falling edge freezes it into hhold_q, which is published on the
    // next report so high_time always pairs with the period it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q      <= '0;
            hhold_q     <= '0;
            high_time_q <= '0;
        end else if (clr) begin
            hcnt_q      <= '0;
            hhold_q     <= '0;
            high_time_q <= '0;
        end else begin
            if (rise) begin
                hcnt_q <= ONE_C;
            end else if (s_sync) begin
                hcnt_q <= sat_inc(hcnt_q);
            end
            if (fall) begin
                hhold_q <= hcnt_q;
            end
            if (report) begin
                high_time_q <= hhold_q;
            end
        end
    end

    assign high_time = high_time_q;
`else
    assign high_time = '0;
`endif

endmodule

// File: tb/tb_period_meter.sv
module tb_period_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 50;

`ifdef PERIOD_METER_HIGH_EN
    localparam bit HIGH_EN = 1'b1;
`else
    localparam bit HIGH_EN = 1'b0;
`endif

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             sig_in = 1'b0;
    logic             clr    = 1'b0;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             locked;
    logic             timeout;
    logic [CNT_W-1:0] high_time;

    int n_tests = 0;
    int n_fail  = 0;

    period_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .clr       (clr),
        .period    (period),
        .valid     (valid),
        .locked    (locked),
        .timeout   (timeout),
        .high_time (high_time)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One signal period: hi cycles high then lo cycles low. The rise reaches
    // the outputs on the third edge after sig_in goes high (i == 2), and the
    // pulse must be gone one edge later.
    task automatic sig_cycle(input string tag, input int hi, input int lo,
                             input logic exp_v, input int exp_p,
                             input logic exp_l, input int exp_h);
        for (int i = 0; i < hi + lo; i++) begin
            sig_in = (i < hi);
            step();
            if (i == 2) begin
                check_eq({tag, ".valid"},  32'(valid),     32'(exp_v));
                check_eq({tag, ".period"}, 32'(period),    32'(exp_p));
                check_eq({tag, ".locked"}, 32'(locked),    32'(exp_l));
                check_eq({tag, ".high"},   32'(high_time), HIGH_EN ? 32'(exp_h) : 32'd0);
            end else if (i == 3) begin
                check_eq({tag, ".pulse"},  32'(valid),     32'd0);
            end
        end
    endtask

    initial begin
        // Reset held while the input toggles
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sig_in = ~sig_in;
            step();
        end
        check_eq("rst.period",  32'(period),    32'd0);
        check_eq("rst.valid",   32'(valid),     32'd0);
        check_eq("rst.locked",  32'(locked),    32'd0);
        check_eq("rst.timeout", 32'(timeout),   32'd0);
        check_eq("rst.high",    32'(high_time), 32'd0);
        sig_in = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (4) step();

        // Steady toggle every 5 cycles: first rise arms only
        sig_cycle("arm",   5, 5, 1'b0, 0,  1'b0, 0);
        sig_cycle("tog1",  5, 5, 1'b1, 10, 1'b1, 5);
        sig_cycle("tog2",  5, 5, 1'b1, 10, 1'b1, 5);
        check_eq("tog.timeout", 32'(timeout), 32'd0);
        sig_cycle("tog3",  5, 5, 1'b1, 10, 1'b1, 5);

        // Duty cycle 3 high / 7 low
        sig_cycle("duty1", 3, 7, 1'b1, 10, 1'b1, 5);
        sig_cycle("duty2", 3, 7, 1'b1, 10, 1'b1, 3);

        // Half-period change 5 -> 8: one transitional report then 16
        sig_cycle("chg1",  8, 8, 1'b1, 10, 1'b1, 3);
        sig_cycle("chg2",  8, 8, 1'b1, 16, 1'b1, 8);
        sig_cycle("chg3",  8, 8, 1'b1, 16, 1'b1, 8);

        // Loss of signal: counter reloaded 13 edges ago, limit is 50 edges
        repeat (36) step();
        check_eq("los.pre_timeout", 32'(timeout), 32'd0);
        check_eq("los.pre_locked",  32'(locked),  32'd1);
        step();
        check_eq("los.timeout", 32'(timeout), 32'd1);
        check_eq("los.locked",  32'(locked),  32'd0);
        check_eq("los.period",  32'(period),  32'd16);
        repeat (5) step();
        check_eq("los.sticky",  32'(timeout), 32'd1);
        check_eq("los.novalid", 32'(valid),   32'd0);

        // Restart after stall
        sig_cycle("rearm", 5, 5, 1'b0, 16, 1'b0, 8);
        sig_cycle("rerun", 5, 5, 1'b1, 10, 1'b1, 5);
        check_eq("rerun.timeout", 32'(timeout), 32'd1);

        // clr in the same cycle as a rise
        sig_in = 1'b1;
        step();
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_eq("col.valid",   32'(valid),     32'd0);
        check_eq("col.period",  32'(period),    32'd0);
        check_eq("col.timeout", 32'(timeout),   32'd0);
        check_eq("col.locked",  32'(locked),    32'd0);
        check_eq("col.high",    32'(high_time), 32'd0);
        sig_in = 1'b0;
        repeat (7) step();
        sig_cycle("col.arm", 5, 5, 1'b0, 0,  1'b0, 0);
        sig_cycle("col.run", 5, 5, 1'b1, 10, 1'b1, 5);

        // Asynchronous reset mid-measurement, checked before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst.period",  32'(period),    32'd0);
        check_eq("arst.locked",  32'(locked),    32'd0);
        check_eq("arst.valid",   32'(valid),     32'd0);
        check_eq("arst.high",    32'(high_time), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
